// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Time-multiplexed scan driver for a multi-digit seven-segment
//               display. Accepts a packed hex value over valid/ready and holds
//               it in a one-entry buffer. The buffered value is promoted to the
//               displayed value at each frame boundary. Each digit slot starts
//               with a blank interval to suppress ghosting. Optional
//               leading-zero blanking turns off unused high digits.
// Ports       :
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   value_in     in   packed hex value, digit i = value_in[4i+3:4i]
//   value_valid  in   producer offers value_in
//   value_ready  out  buffer empty, so a transfer occurs on valid & ready
//   lz_blank_en  in   enable leading-zero blanking
//   digit_nibble out  nibble of the digit being scanned, to the hex decoder
//   digit_blank  out  1 = segments forced off
//   an           out  active-low anode enables, at most one bit low
// Revision    : 1.0  initial release
// ============================================================================
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    input  logic                      value_valid,
    output logic                      value_ready,
    input  logic                      lz_blank_en,
    output logic [3:0]                digit_nibble,
    output logic                      digit_blank,
    output logic [NUM_DIGITS-1:0]     an
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] c_idx_one   = IDX_W'(1);
    localparam logic [CNT_W-1:0] c_last_cnt  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] c_blank_end = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [CNT_W-1:0]          r_slot_cnt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic [IDX_W-1:0]          r_digit_idx;
    logic [IDX_W-1:0]          w_idx_nxt;
    logic [4*NUM_DIGITS-1:0]   r_display;
    logic [4*NUM_DIGITS-1:0]   r_pending;
    logic                      r_pending_full;
    logic [NUM_DIGITS-1:0]     r_an;
    logic                      r_blank;
    logic [3:0]                r_nibble;

    logic                      w_frame_end;
    logic                      w_accept;
    logic                      w_load_disp;
    logic [4*NUM_DIGITS-1:0]   w_disp_nxt;
    logic [NUM_DIGITS-1:0]     w_an_nxt;
    logic [3:0]                w_nibble_nxt;
    logic                      w_blank_nxt;
    logic                      w_blank_lz;
    logic                      w_zero_run;

    assign value_ready  = ~r_pending_full;
    assign an           = r_an;
    assign digit_blank  = r_blank;
    assign digit_nibble = r_nibble;

    // The slot counter runs straight through the blank and show phases of a
    // slot; it only returns to zero at the end of the slot.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_slot_cnt + c_cnt_one;
        w_idx_nxt   = r_digit_idx;
        w_frame_end = 1'b0;
        case (r_state)
            ST_BLANK: begin
                if (r_slot_cnt == c_blank_end) begin
                    w_state_nxt = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (r_slot_cnt == c_last_cnt) begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                    w_frame_end = (r_digit_idx == c_last_idx);
                    w_idx_nxt   = (r_digit_idx == c_last_idx) ? '0
                                                              : r_digit_idx + c_idx_one;
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Ready is low whenever the buffer is full, so acceptance and promotion
    // can never collide on the same edge.
    assign w_accept    = value_valid & ~r_pending_full;
    assign w_load_disp = w_frame_end & r_pending_full;
    assign w_disp_nxt  = w_load_disp ? r_pending : r_display;

    // Outputs are registered from the next-cycle view of state, digit index
    // and display value, so they line up exactly with the state register.
    // The scan runs from the top digit down, accumulating "all digits from
    // here upward are zero" for the leading-zero test.
    always_comb begin
        w_zero_run   = 1'b1;
        w_blank_lz   = 1'b0;
        w_nibble_nxt = 4'h0;
        w_an_nxt     = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run & (w_disp_nxt[4*i +: 4] == 4'h0);
            if (IDX_W'(i) == w_idx_nxt) begin
                w_nibble_nxt = w_disp_nxt[4*i +: 4];
                w_blank_lz   = w_zero_run;
                if (w_state_nxt == ST_SHOW) begin
                    w_an_nxt[i] = 1'b0;
                end
            end
        end
        // Digit 0 is never suppressed so an all-zero value still shows "0".
        w_blank_nxt = (w_state_nxt == ST_BLANK)
                    | (lz_blank_en & (w_idx_nxt != '0) & w_blank_lz);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_BLANK;
            r_slot_cnt  <= '0;
            r_digit_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_slot_cnt  <= w_cnt_nxt;
            r_digit_idx <= w_idx_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_display      <= '0;
            r_pending      <= '0;
            r_pending_full <= 1'b0;
        end else begin
            r_display <= w_disp_nxt;
            if (w_accept) begin
                r_pending      <= value_in;
                r_pending_full <= 1'b1;
            end else if (w_load_disp) begin
                r_pending_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an     <= '1;
            r_blank  <= 1'b1;
            r_nibble <= 4'h0;
        end else begin
            r_an     <= w_an_nxt;
            r_blank  <= w_blank_nxt;
            r_nibble <= w_nibble_nxt;
        end
    end

endmodule
`default_nettype wire
